// File: rtl/counter_pkg.sv
// counter_pkg: shared types, default widths and terminal/reload helpers for
// the multi_counter timer bank.
package counter_pkg;

  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_BIT_NUM = 8;
  localparam int unsigned MAX_NUM_CH  = 16;
  localparam int unsigned MAX_BIT_NUM = 32;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } count_dir_t;

  typedef enum logic {
    WRAP     = 1'b0,
    ONE_SHOT = 1'b1
  } count_mode_t;

  // Terminal value: the period value when counting up, zero when counting down.
  function automatic logic [MAX_BIT_NUM-1:0] terminal_sel(
    input count_dir_t             dir,
    input logic [MAX_BIT_NUM-1:0] period
  );
    return (dir == DOWN) ? '0 : period;
  endfunction

  // Reload point after a wrap: the opposite end of the range from the terminal.
  function automatic logic [MAX_BIT_NUM-1:0] reload_sel(
    input count_dir_t             dir,
    input logic [MAX_BIT_NUM-1:0] period
  );
    return (dir == DOWN) ? period : '0;
  endfunction

  // Terminal detection. Counting up uses >= so a period lowered below the
  // current count still wraps instead of running on to 2^BIT_NUM.
  function automatic logic at_terminal(
    input count_dir_t             dir,
    input logic [MAX_BIT_NUM-1:0] count,
    input logic [MAX_BIT_NUM-1:0] period
  );
    return (dir == DOWN) ? (count == '0) : (count >= period);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one programmable up/down counter with wrap or one-shot
// behaviour.
//   CLK, nRST      clock, async active-low reset
//   count_en       count enable
//   count_clear    synchronous clear (highest priority)
//   load_en        synchronous load of load_val
//   load_val       load value (not clamped)
//   rollover_val   period / terminal value
//   dir_down       1 = count down, 0 = count up
//   one_shot       1 = stop at terminal, 0 = wrap
//   count_val      registered count
//   rollover_flag  registered, high while count equals terminal value
//   wrap_pulse     registered one-cycle pulse after a wrap
//   done           sticky, one-shot channel reached terminal
//   wrap_nxt_c     combinational next value of wrap_pulse (feeds top irq)
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned BIT_NUM = DEF_BIT_NUM
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               count_en,
  input  logic               count_clear,
  input  logic               load_en,
  input  logic [BIT_NUM-1:0] load_val,
  input  logic [BIT_NUM-1:0] rollover_val,
  input  logic               dir_down,
  input  logic               one_shot,
  output logic [BIT_NUM-1:0] count_val,
  output logic               rollover_flag,
  output logic               wrap_pulse,
  output logic               done,
  output logic               wrap_nxt_c
);

  count_dir_t         dir;
  count_mode_t        mode;
  logic [BIT_NUM-1:0] term;
  logic [BIT_NUM-1:0] reload;
  logic               at_term;
  logic [BIT_NUM-1:0] cnt_nxt;
  logic               done_nxt;
  logic               flag_nxt;

  // Decode direction/mode and derive terminal and reload points.
  always_comb begin
    dir     = dir_down ? DOWN : UP;
    mode    = one_shot ? ONE_SHOT : WRAP;
    term    = BIT_NUM'(terminal_sel(dir, MAX_BIT_NUM'(rollover_val)));
    reload  = BIT_NUM'(reload_sel(dir, MAX_BIT_NUM'(rollover_val)));
    at_term = at_terminal(dir, MAX_BIT_NUM'(count_val), MAX_BIT_NUM'(rollover_val));
  end

  // Next-state: clear > load > count > hold.
  always_comb begin
    cnt_nxt    = count_val;
    done_nxt   = done;
    wrap_nxt_c = 1'b0;
    if (count_clear) begin
      cnt_nxt  = '0;
      done_nxt = 1'b0;
    end else if (load_en) begin
      cnt_nxt  = load_val;
      done_nxt = 1'b0;
    end else if (count_en) begin
      if (at_term) begin
        if (mode == ONE_SHOT) begin
          // Already at terminal: hold and (re)assert done.
          done_nxt = 1'b1;
        end else begin
          cnt_nxt    = reload;
          wrap_nxt_c = 1'b1;
        end
      end else begin
        cnt_nxt = (dir == DOWN) ? (count_val - BIT_NUM'(1))
                                : (count_val + BIT_NUM'(1));
        if ((mode == ONE_SHOT) && (cnt_nxt == term)) begin
          done_nxt = 1'b1;
        end
      end
    end
    // Flag tracks the next count against the current-cycle terminal so it
    // is also correct straight after a clear or load.
    flag_nxt = (cnt_nxt == term);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_val     <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
      done          <= 1'b0;
    end else begin
      count_val     <= cnt_nxt;
      rollover_flag <= flag_nxt;
      wrap_pulse    <= wrap_nxt_c;
      done          <= done_nxt;
    end
  end

endmodule

// File: rtl/multi_counter.sv
// multi_counter: bank of NUM_CH independent programmable counters used as
// bit timers, retry counters and timeouts.
//   CLK, nRST      clock, async active-low reset
//   count_en       per-channel count enable
//   count_clear    per-channel synchronous clear
//   load_en        per-channel synchronous load strobe
//   load_val       packed load values, channel i at [i*BIT_NUM +: BIT_NUM]
//   rollover_val   packed period values, same packing
//   dir_down       per-channel direction (1 = down)
//   one_shot       per-channel mode (1 = one-shot)
//   count_val      packed current counts, same packing
//   rollover_flag  per-channel terminal flag
//   wrap_pulse     per-channel wrap pulse
//   done           per-channel sticky one-shot done
//   irq            registered OR of the next-state wrap pulses
module multi_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned BIT_NUM = DEF_BIT_NUM
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_CH-1:0]         count_en,
  input  logic [NUM_CH-1:0]         count_clear,
  input  logic [NUM_CH-1:0]         load_en,
  input  logic [NUM_CH*BIT_NUM-1:0] load_val,
  input  logic [NUM_CH*BIT_NUM-1:0] rollover_val,
  input  logic [NUM_CH-1:0]         dir_down,
  input  logic [NUM_CH-1:0]         one_shot,
  output logic [NUM_CH*BIT_NUM-1:0] count_val,
  output logic [NUM_CH-1:0]         rollover_flag,
  output logic [NUM_CH-1:0]         wrap_pulse,
  output logic [NUM_CH-1:0]         done,
  output logic                      irq
);

  logic [NUM_CH-1:0] wrap_nxt;

  // One counter per channel; the top only slices the packed buses.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_channel #(
      .BIT_NUM (BIT_NUM)
    ) u_ch (
      .CLK           (CLK),
      .nRST          (nRST),
      .count_en      (count_en[g]),
      .count_clear   (count_clear[g]),
      .load_en       (load_en[g]),
      .load_val      (load_val[g*BIT_NUM +: BIT_NUM]),
      .rollover_val  (rollover_val[g*BIT_NUM +: BIT_NUM]),
      .dir_down      (dir_down[g]),
      .one_shot      (one_shot[g]),
      .count_val     (count_val[g*BIT_NUM +: BIT_NUM]),
      .rollover_flag (rollover_flag[g]),
      .wrap_pulse    (wrap_pulse[g]),
      .done          (done[g]),
      .wrap_nxt_c    (wrap_nxt[g])
    );
  end

  // Interrupt registered alongside the wrap pulses so both assert together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      irq <= 1'b0;
    end else begin
      irq <= |wrap_nxt;
    end
  end

endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: scoreboard bench for multi_counter. Each cycle the bench
// model predicts the post-edge outputs, pushes them to a queue, and pops and
// compares them once the DUT has clocked.
module tb_multi_counter;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned BIT_NUM = 8;
  localparam int unsigned VW      = NUM_CH * BIT_NUM;

  logic                 CLK;
  logic                 nRST;
  logic [NUM_CH-1:0]    count_en;
  logic [NUM_CH-1:0]    count_clear;
  logic [NUM_CH-1:0]    load_en;
  logic [VW-1:0]        load_val;
  logic [VW-1:0]        rollover_val;
  logic [NUM_CH-1:0]    dir_down;
  logic [NUM_CH-1:0]    one_shot;
  logic [VW-1:0]        count_val;
  logic [NUM_CH-1:0]    rollover_flag;
  logic [NUM_CH-1:0]    wrap_pulse;
  logic [NUM_CH-1:0]    done;
  logic                 irq;

  logic [BIT_NUM-1:0]   lv [NUM_CH];
  logic [BIT_NUM-1:0]   rv [NUM_CH];

  logic [BIT_NUM-1:0]   m_cnt  [NUM_CH];
  logic                 m_done [NUM_CH];

  typedef struct {
    logic [VW-1:0]     cnt;
    logic [NUM_CH-1:0] flag;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] done;
    logic              irq;
  } exp_t;

  exp_t sb [$];

  int n_checks = 0;
  int n_errors = 0;

  int exp1 [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  int exp2 [6]  = '{3, 2, 1, 0, 0, 0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign load_val[g*BIT_NUM +: BIT_NUM]     = lv[g];
    assign rollover_val[g*BIT_NUM +: BIT_NUM] = rv[g];
  end

  multi_counter #(
    .NUM_CH  (NUM_CH),
    .BIT_NUM (BIT_NUM)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .count_en      (count_en),
    .count_clear   (count_clear),
    .load_en       (load_en),
    .load_val      (load_val),
    .rollover_val  (rollover_val),
    .dir_down      (dir_down),
    .one_shot      (one_shot),
    .count_val     (count_val),
    .rollover_flag (rollover_flag),
    .wrap_pulse    (wrap_pulse),
    .done          (done),
    .irq           (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BIT_NUM-1:0] ch_cnt(input int ch);
    return count_val[ch*BIT_NUM +: BIT_NUM];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c]  = '0;
      m_done[c] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    count_en = '0; count_clear = '0; load_en = '0;
    dir_down = '0; one_shot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lv[c] = '0;
      rv[c] = '0;
    end
  endtask

  // Predict next outputs from current inputs, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    exp_t r;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [BIT_NUM-1:0] n;
      logic d;
      logic w;
      n = m_cnt[c];
      d = m_done[c];
      w = 1'b0;
      if (count_clear[c]) begin
        n = '0; d = 1'b0;
      end else if (load_en[c]) begin
        n = lv[c]; d = 1'b0;
      end else if (count_en[c]) begin
        if (!dir_down[c]) begin
          if (m_cnt[c] >= rv[c]) begin
            if (one_shot[c]) d = 1'b1;
            else begin n = '0; w = 1'b1; end
          end else begin
            n = m_cnt[c] + 8'd1;
            if (one_shot[c] && n == rv[c]) d = 1'b1;
          end
        end else begin
          if (m_cnt[c] == 8'd0) begin
            if (one_shot[c]) d = 1'b1;
            else begin n = rv[c]; w = 1'b1; end
          end else begin
            n = m_cnt[c] - 8'd1;
            if (one_shot[c] && n == 8'd0) d = 1'b1;
          end
        end
      end
      e.cnt[c*BIT_NUM +: BIT_NUM] = n;
      e.flag[c] = dir_down[c] ? (n == 8'd0) : (n == rv[c]);
      e.wrap[c] = w;
      e.done[c] = d;
      m_cnt[c]  = n;
      m_done[c] = d;
    end
    e.irq = |e.wrap;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      r = sb.pop_front();
      check("count_val", 64'(count_val), 64'(r.cnt));
      check("rollover_flag", 64'(rollover_flag), 64'(r.flag));
      check("wrap_pulse", 64'(wrap_pulse), 64'(r.wrap));
      check("done", 64'(done), 64'(r.done));
      check("irq", 64'(irq), 64'(r.irq));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"},  64'(count_val), 64'd0);
    check({tag, "_flag"}, 64'(rollover_flag), 64'd0);
    check({tag, "_wrap"}, 64'(wrap_pulse), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_irq"},  64'(irq), 64'd0);
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all_zero("reset");
    nRST = 1'b1;

    // ch0 up/wrap, period 3
    rv[0] = 8'd3; count_en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t1_cnt",  64'(ch_cnt(0)), 64'(exp1[k]));
      check("t1_flag", 64'(rollover_flag[0]), 64'(exp1[k] == 3));
      check("t1_wrap", 64'(wrap_pulse[0]), 64'(k > 0 && exp1[k] == 0));
      check("t1_irq",  64'(irq), 64'(k > 0 && exp1[k] == 0));
    end
    count_en[0] = 1'b0;

    // ch1 down/one-shot from 4
    dir_down[1] = 1'b1; one_shot[1] = 1'b1; lv[1] = 8'd4; load_en[1] = 1'b1;
    step();
    check("t2_load", 64'(ch_cnt(1)), 64'd4);
    load_en[1] = 1'b0; count_en[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_cnt",  64'(ch_cnt(1)), 64'(exp2[k]));
      check("t2_done", 64'(done[1]), 64'(exp2[k] == 0));
      check("t2_wrap", 64'(wrap_pulse[1]), 64'd0);
      check("t2_irq",  64'(irq), 64'd0);
    end
    count_en[1] = 1'b0;

    // ch2 priority
    lv[2] = 8'd9; count_clear[2] = 1'b1; load_en[2] = 1'b1; count_en[2] = 1'b1;
    step();
    check("t3_clr_cnt",  64'(ch_cnt(2)), 64'd0);
    check("t3_clr_done", 64'(done[2]), 64'd0);
    count_clear[2] = 1'b0;
    step();
    check("t3_ld_cnt", 64'(ch_cnt(2)), 64'd9);
    load_en[2] = 1'b0; count_en[2] = 1'b0;

    // ch3 runtime period reduction below current count
    rv[3] = 8'd255; lv[3] = 8'd200; load_en[3] = 1'b1;
    step();
    check("t4_load", 64'(ch_cnt(3)), 64'd200);
    load_en[3] = 1'b0; rv[3] = 8'd10; count_en[3] = 1'b1;
    step();
    check("t4_wrap_cnt", 64'(ch_cnt(3)), 64'd0);
    check("t4_wrap",     64'(wrap_pulse[3]), 64'd1);
    check("t4_irq",      64'(irq), 64'd1);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("t4_cnt",  64'(ch_cnt(3)), 64'((k == 11) ? 0 : k));
      check("t4_wrp",  64'(wrap_pulse[3]), 64'(k == 11));
    end
    count_en[3] = 1'b0;

    // ch0 period 0: stuck at 0, wrap every enabled cycle
    rv[0] = 8'd0; count_en[0] = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_cnt",  64'(ch_cnt(0)), 64'd0);
      check("t5_flag", 64'(rollover_flag[0]), 64'd1);
      check("t5_wrap", 64'(wrap_pulse[0]), 64'd1);
    end

    // Random mixed traffic on all channels
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_clear[c] = ($urandom_range(0, 19) == 0);
        load_en[c]     = ($urandom_range(0, 9) == 0);
        count_en[c]    = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) dir_down[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) one_shot[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) rv[c] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
        lv[c] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      end
      step();
    end

    // Async reset mid-count
    idle_inputs();
    for (int c = 0; c < NUM_CH; c++) rv[c] = 8'd20;
    count_en = '1;
    for (int k = 0; k < 5; k++) step();
    #2;
    nRST = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #8;
    nRST = 1'b1;

    // Resume: independent channel setups from 0
    idle_inputs();
    rv[0] = 8'd5;                                count_en[0] = 1'b1;
    rv[1] = 8'd3; dir_down[1] = 1'b1;            count_en[1] = 1'b1;
    rv[2] = 8'd2; one_shot[2] = 1'b1;            count_en[2] = 1'b1;
    step();
    check("resume_ch0", 64'(ch_cnt(0)), 64'd1);
    check("resume_ch1", 64'(ch_cnt(1)), 64'd3);
    check("resume_ch3", 64'(ch_cnt(3)), 64'd0);
    for (int k = 0; k < 8; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
- Parametrised bank of NUM_CH independent programmable counters. Each channel has per-channel up/down direction, wrap or one-shot mode, synchronous load, clear, a terminal-count flag, a wrap pulse and a sticky done bit.
- A registered aggregate interrupt is raised when any channel wraps.
- Serves as the general timer/counter resource for the NVM controller: bit timers, retry counters and timeouts.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- BIT_NUM, 8, counter width per channel (2..32).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- count_en  in  NUM_CH  per-channel count enable.
- count_clear  in  NUM_CH  per-channel synchronous clear.
- load_en  in  NUM_CH  per-channel synchronous load strobe.
- load_val  in  NUM_CH*BIT_NUM  load values; channel i uses bits [i*BIT_NUM +: BIT_NUM].
- rollover_val  in  NUM_CH*BIT_NUM  per-channel terminal/period value; same packing as load_val.
- dir_down  in  NUM_CH  1 = count down, 0 = count up.
- one_shot  in  NUM_CH  1 = stop at terminal, 0 = wrap.
- count_val  out  NUM_CH*BIT_NUM  current counts; same packing as load_val.
- rollover_flag  out  NUM_CH  registered; high while count equals the channel's terminal value.
- wrap_pulse  out  NUM_CH  registered one-cycle pulse after a wrap.
- done  out  NUM_CH  sticky; one-shot channel reached terminal.
- irq  out  1  registered OR of the next-state wrap_pulse vector.

Behaviour:
- Single clock domain CLK. Reset nRST is asynchronous, active-low. All state and outputs are flops with no combinational paths to outputs.
- Reset values: count_val=0, rollover_flag=0, wrap_pulse=0, done=0, irq=0.
- Terminal value T per channel: up mode T=rollover_val, down mode T=0. The reload point is 0 (up) or rollover_val (down).
- Per-channel priority each cycle: count_clear > load_en > count_en > hold.
- count_clear: count←0, done←0, wrap_pulse←0.
- load_en: count←load_val, done←0. load_val is not clamped.
- count_en, wrap mode, up direction: if count ≥ rollover_val, count←0 and wrap_pulse←1; else count+1.
- count_en, wrap mode, down direction: if count==0, count←rollover_val and wrap_pulse←1; else count−1.
- count_en, one-shot mode:
  - Same stepping as wrap mode, but at terminal the count holds and does not reload.
  - done←1 on the cycle the terminal is reached or is already present with count_en=1.
  - wrap_pulse is never asserted in one-shot mode.
- Count period in wrap mode is rollover_val+1 enabled cycles. rollover_val=0 gives count stuck at 0 and wrap_pulse every enabled cycle.
- rollover_flag next = (next count == T), with T evaluated from the current-cycle rollover_val and dir_down. The flag is correct after clear and load too.
  - Example: up, rollover_val=5 → flag high exactly while count_val=5.
- wrap_pulse is 0 in any cycle without a wrap. It never stays high for two cycles unless wraps occur on consecutive enabled cycles.
- irq next = |(next wrap_pulse).
- Arithmetic is modulo 2^BIT_NUM. The ≥ comparison in up mode means a rollover_val lowered below the current count wraps on the next enable and never overflows to 2^BIT_NUM.
- dir_down, one_shot and rollover_val changes take effect on the next edge; there is no shadowing.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset asserted mid-count forces all outputs to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package counter_pkg:
  - Typedef count_dir_t (UP, DOWN).
  - Typedef count_mode_t (WRAP, ONE_SHOT).
  - Function for terminal selection.
  - Default-width constants.
- Sub-module counter_channel (one channel, BIT_NUM parameter), instantiated NUM_CH times in a generate loop.
- Top level only slices the packed vectors and ORs the irq term.

Test Plan:
- Reset check: BIT_NUM=8, ch0 up/wrap, rollover_val=3, count_en=1 for 10 cycles.
  - count_val 1,2,3,0,1,2,3,0,1,2.
  - rollover_flag high on the 3s.
  - wrap_pulse and irq high on each cycle showing 0 after a 3.
- ch1 down/one-shot: load_val=4, then count_en held.
  - count 4,3,2,1,0,0,…
  - done rises on the edge count reaches 0 and stays high.
  - wrap_pulse and irq stay 0.
- Priority: ch2 with count_clear, load_en (load_val=9) and count_en all asserted in one cycle → count 0, done 0. Next cycle load_en+count_en → count 9.
- Runtime change: ch3 up at count=200, rollover_val switched to 10, count_en=1 → next count 0 with wrap_pulse=1; the following period is 0..10.
- rollover_val=0, up/wrap, count_en=1 → count stays 0, rollover_flag=1, wrap_pulse=1 every cycle.
- Async reset: assert nRST low between clock edges mid-count on all channels → all outputs 0 immediately. After release, counting resumes from 0 and channels are unaffected by each other.
